// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic inter-stage pipeline register with a valid/ready
// handshake and a 2-entry skid buffer (main + skid), synchronous flush with
// bubble insertion, and optional performance counters.
// All state updates on the falling edge of i_clock; i_reset is async active-low.
// Optional feature macro: PIPE_STAGE_PERF_EN (stall/bubble cycle counters).
module pipe_stage_skid #(
  parameter int unsigned CTRL_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count,
  input  logic                  i_perf_clear,
  output logic [CNT_WIDTH-1:0]  o_stall_cycles,
  output logic [CNT_WIDTH-1:0]  o_bubble_cycles
);

  // Encoding equals occupancy so o_count is the state register itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CTRL_WIDTH-1:0] r_main_ctrl, w_main_ctrl_nxt;
  logic [DATA_WIDTH-1:0] r_main_data, w_main_data_nxt;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl, w_skid_ctrl_nxt;
  logic [DATA_WIDTH-1:0] r_skid_data, w_skid_data_nxt;
  logic                  w_in;
  logic                  w_out;

  // Handshake flags decoded from state only: no combinational path from i_ready/i_valid.
  assign o_valid = (r_state != S_EMPTY);
  assign o_ready = (r_state != S_FULL);
  assign o_count = r_state;
  assign o_ctrl  = r_main_ctrl;
  assign o_data  = r_main_data;

  assign w_in  = i_valid & o_ready;
  assign w_out = o_valid & i_ready;

  // Next-state and storage update; flush wins and zeroes the visible control bus.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (i_flush) begin
      w_state_nxt     = S_EMPTY;
      w_main_ctrl_nxt = '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in) begin
            w_state_nxt     = S_ONE;
            w_main_ctrl_nxt = i_ctrl;
            w_main_data_nxt = i_data;
          end
        end
        S_ONE: begin
          if (w_in && w_out) begin
            w_main_ctrl_nxt = i_ctrl;
            w_main_data_nxt = i_data;
          end else if (w_in) begin
            w_state_nxt     = S_FULL;
            w_skid_ctrl_nxt = i_ctrl;
            w_skid_data_nxt = i_data;
          end else if (w_out) begin
            // Drained: keep data stable, but ctrl must read 0 while invalid.
            w_state_nxt     = S_EMPTY;
            w_main_ctrl_nxt = '0;
          end
        end
        S_FULL: begin
          if (w_out) begin
            w_state_nxt     = S_ONE;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
          end
        end
        default: begin
          w_state_nxt     = S_EMPTY;
          w_main_ctrl_nxt = '0;
        end
      endcase
    end
  end

  // State and entry registers, falling-edge clocked with async active-low reset.
  always_ff @(negedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_bubble_cnt;

  // Saturating stall/bubble counters; clear beats increment, flush has no effect.
  always_ff @(negedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (i_perf_clear) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (o_valid && !i_ready && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
      if (!o_valid && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_stall_cycles  = r_stall_cnt;
  assign o_bubble_cycles = r_bubble_cnt;
`else
  logic w_unused_perf_clear;

  // Counters not built: outputs tied low, clear input intentionally ignored.
  assign w_unused_perf_clear = i_perf_clear;
  assign o_stall_cycles      = '0;
  assign o_bubble_cycles     = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized valid/ready/flush
// traffic, checked against a queue-based FIFO model of at most two entries.
// Counter expectations follow PIPE_STAGE_PERF_EN (CNT_WIDTH=4 here).
module tb_pipe_stage_skid;

  localparam int unsigned CW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned NW  = 4;
  localparam int unsigned MAX = 15;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } entry_t;

  logic          i_clock;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [CW-1:0] i_ctrl;
  logic [DW-1:0] i_data;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [CW-1:0] o_ctrl;
  logic [DW-1:0] o_data;
  logic [1:0]    o_count;
  logic          i_perf_clear;
  logic [NW-1:0] o_stall_cycles;
  logic [NW-1:0] o_bubble_cycles;

  entry_t q[$];
  int     m_stall;
  int     m_bubble;
  int     n_tests;
  int     n_fail;

  pipe_stage_skid #(
    .CTRL_WIDTH(CW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (NW)
  ) u_dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_ctrl         (i_ctrl),
    .i_data         (i_data),
    .i_flush        (i_flush),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_ctrl         (o_ctrl),
    .o_data         (o_data),
    .o_count        (o_count),
    .i_perf_clear   (i_perf_clear),
    .o_stall_cycles (o_stall_cycles),
    .o_bubble_cycles(o_bubble_cycles)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of one falling edge: FIFO of depth 2, flush empties it.
  task automatic model_edge(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                            input logic r, input logic f, input logic pc);
    int     sz;
    entry_t e;
    sz = q.size();
`ifdef PIPE_STAGE_PERF_EN
    if (pc) begin
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (sz > 0 && !r && m_stall < MAX) m_stall++;
      if (sz == 0 && m_bubble < MAX) m_bubble++;
    end
`endif
    if (f) begin
      q.delete();
    end else begin
      if (sz > 0 && r) void'(q.pop_front());
      if (v && sz < 2) begin
        e.c = c;
        e.d = d;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_all();
    logic   m_v;
    entry_t h;
    m_v = (q.size() != 0);
    check_eq("o_valid", 128'(o_valid), 128'(m_v));
    check_eq("o_ready", 128'(o_ready), 128'(q.size() < 2));
    check_eq("o_count", 128'(o_count), 128'(q.size()));
    if (m_v) begin
      h = q[0];
      check_eq("o_ctrl", 128'(o_ctrl), 128'(h.c));
      check_eq("o_data", 128'(o_data), 128'(h.d));
    end else begin
      check_eq("o_ctrl_idle", 128'(o_ctrl), 128'(0));
    end
    check_eq("o_stall_cycles", 128'(o_stall_cycles), 128'(m_stall));
    check_eq("o_bubble_cycles", 128'(o_bubble_cycles), 128'(m_bubble));
  endtask

  // Drive inputs just after the rising edge, let the falling edge act, check after next rise.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic r, input logic f, input logic pc);
    i_valid      = v;
    i_ctrl       = c;
    i_data       = d;
    i_ready      = r;
    i_flush      = f;
    i_perf_clear = pc;
    @(negedge i_clock);
    model_edge(v, c, d, r, f, pc);
    @(posedge i_clock);
    #1;
    check_all();
  endtask

  task automatic reset_checks();
    check_eq("rst_o_valid", 128'(o_valid), 128'(0));
    check_eq("rst_o_ready", 128'(o_ready), 128'(1));
    check_eq("rst_o_count", 128'(o_count), 128'(0));
    check_eq("rst_o_ctrl", 128'(o_ctrl), 128'(0));
    check_eq("rst_o_data", 128'(o_data), 128'(0));
    check_eq("rst_stall", 128'(o_stall_cycles), 128'(0));
    check_eq("rst_bubble", 128'(o_bubble_cycles), 128'(0));
  endtask

  initial begin
    logic          pv;
    logic [CW-1:0] pc_ctrl;
    logic [DW-1:0] pd;
    logic          r;
    logic          f;
    logic          clr;
    logic          acc;

    n_tests      = 0;
    n_fail       = 0;
    m_stall      = 0;
    m_bubble     = 0;
    i_reset      = 1'b0;
    i_valid      = 1'b0;
    i_ctrl       = '0;
    i_data       = '0;
    i_ready      = 1'b0;
    i_flush      = 1'b0;
    i_perf_clear = 1'b0;

    // Power-on reset state, then release away from the falling edge.
    #12;
    reset_checks();
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;

    // Fill to FULL, then assert reset asynchronously mid-cycle.
    step(1'b1, 16'h0001, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0);
    check_eq("full_count", 128'(o_count), 128'(2));
    #2;
    i_reset = 1'b0;
    #1;
    reset_checks();
    q.delete();
    m_stall  = 0;
    m_bubble = 0;
    i_valid  = 1'b0;
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;

    // First transfer after reset: visible one edge later.
    step(1'b1, 16'h00A5, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    check_eq("first_ctrl", 128'(o_ctrl), 128'(16'h00A5));
    check_eq("first_data", 128'(o_data), 128'(32'h1234));
    step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Streaming at full throughput: occupancy stays at one.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, CW'(i), DW'(i), 1'b1, 1'b0, 1'b0);
      check_eq("stream_data", 128'(o_data), 128'(i));
      check_eq("stream_count", 128'(o_count), 128'(1));
    end
    step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-pressure fills the skid entry; upstream holds 0x12 until space frees.
    step(1'b1, 16'h0010, 32'h10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0011, 32'h11, 1'b0, 1'b0, 1'b0);
    check_eq("bp_count", 128'(o_count), 128'(2));
    check_eq("bp_ready", 128'(o_ready), 128'(0));
    step(1'b1, 16'h0012, 32'h12, 1'b0, 1'b0, 1'b0);
    check_eq("bp_head", 128'(o_data), 128'(32'h10));
    step(1'b1, 16'h0012, 32'h12, 1'b1, 1'b0, 1'b0);
    check_eq("bp_second", 128'(o_data), 128'(32'h11));
    step(1'b1, 16'h0012, 32'h12, 1'b1, 1'b0, 1'b0);
    check_eq("bp_third", 128'(o_data), 128'(32'h12));
    step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush from FULL with a concurrent input: everything discarded.
    step(1'b1, 16'h0020, 32'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0021, 32'h21, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 32'h22, 1'b0, 1'b1, 1'b0);
    check_eq("flush_valid", 128'(o_valid), 128'(0));
    check_eq("flush_ctrl", 128'(o_ctrl), 128'(0));
    check_eq("flush_count", 128'(o_count), 128'(0));
    step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_eq("flush_stays_empty", 128'(o_valid), 128'(0));

    // Simultaneous in and out while holding one entry.
    step(1'b1, 16'h0030, 32'h30, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0031, 32'h31, 1'b1, 1'b0, 1'b0);
    check_eq("inout_data", 128'(o_data), 128'(32'h31));
    check_eq("inout_count", 128'(o_count), 128'(1));

    // Sustained stall for 20 cycles, then counter clear.
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    check_eq("stall_saturated", 128'(o_stall_cycles), 128'(MAX));
`else
    check_eq("stall_absent", 128'(o_stall_cycles), 128'(0));
`endif
    step(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("stall_cleared", 128'(o_stall_cycles), 128'(0));
    check_eq("bubble_cleared", 128'(o_bubble_cycles), 128'(0));
    step(1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with a well-behaved upstream that holds unaccepted offers.
    pv      = 1'b0;
    pc_ctrl = '0;
    pd      = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv) begin
        pv      = ($urandom_range(0, 99) < 65);
        pc_ctrl = CW'($urandom);
        pd      = DW'($urandom);
      end
      r   = ($urandom_range(0, 99) < 60);
      f   = ($urandom_range(0, 99) < 4);
      clr = ($urandom_range(0, 99) < 3);
      acc = pv && (q.size() < 2) && !f;
      step(pv, pc_ctrl, pd, r, f, clr);
      if (acc || f) pv = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised inter-stage pipeline register. It replaces the fixed per-stage field lists (IF/ID, ID/EX, EX/MEM, MEM/WB) with one packed control bus and one packed data bus.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from a downstream stage does not need a combinational stall path to upstream.
- Adds synchronous flush with bubble insertion (control bus zeroed).
- Sits between any two pipeline stages; the stage top packs and unpacks the fields.

Parameters:
- CTRL_WIDTH, 16: width of the control bus. Forced to 0 on bubble or flush.
- DATA_WIDTH, 128: width of the payload bus (pc, operands, immediate, register indices).
- CNT_WIDTH, 32: width of the performance counters (used only with the optional feature).

Ports:
- i_clock  in  1  stage clock; all state updates on the falling edge, matching the other pipe registers.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream has a transfer.
- o_ready  out  1  this stage can accept a transfer.
- i_ctrl  in  CTRL_WIDTH  upstream control bus.
- i_data  in  DATA_WIDTH  upstream payload.
- i_flush  in  1  synchronous flush; discards all held entries.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_ctrl  out  CTRL_WIDTH  held control; 0 whenever o_valid=0.
- o_data  out  DATA_WIDTH  held payload; undefined-but-stable when o_valid=0.
- o_count  out  2  occupancy, 0..2.
- i_perf_clear  in  1  synchronous clear of the performance counters.
- o_stall_cycles  out  CNT_WIDTH  cycles with o_valid=1 and i_ready=0.
- o_bubble_cycles  out  CNT_WIDTH  cycles with o_valid=0.

Behaviour:
- Storage: main entry (drives outputs) and skid entry. State is EMPTY, ONE or FULL.
- o_ready = (state != FULL). o_valid = (state != EMPTY). o_count = 0/1/2. All three are decoded from state only; no combinational path from i_ready or i_valid.
- in = i_valid & o_ready; out = o_valid & i_ready. Both are evaluated at the falling edge.
- EMPTY:
  - in → ONE, main <= input.
  - otherwise stay in EMPTY.
- ONE:
  - in & out → ONE, main <= input.
  - in & !out → FULL, skid <= input.
  - !in & out → EMPTY.
  - neither → hold.
- FULL (in is impossible):
  - out → ONE, main <= skid.
  - no out → hold all.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- Latency: an input accepted at edge N is on the outputs after edge N (1 cycle). Throughput is 1 per cycle while i_ready=1.
- Flush has the highest priority. At the edge: state → EMPTY, and an input presented in the same cycle is discarded. o_valid=0 and o_ctrl=0 after the edge. A flush with state FULL drops both entries.
- Reset (asserted low, asynchronous, any time including mid-transfer):
  - state=EMPTY, main and skid ctrl/data = 0.
  - o_valid=0, o_ctrl=0, o_data=0, o_count=0, o_ready=1.
  - Counters = 0.
- After reset deassertion, the first falling edge may accept.
- Widths are pure pass-through; no sign or zero extension.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - o_stall_cycles increments at each edge with o_valid & !i_ready.
  - o_bubble_cycles increments at each edge with !o_valid.
  - Both saturate at all-ones and do not wrap.
  - i_perf_clear zeroes both at that edge and has priority over increment.
  - Flush does not clear the counters.
- Not defined: ports remain present, outputs are tied to 0, i_perf_clear is ignored, and no counter flops are built.

Test Plan:
- Reset low mid-stream with state FULL → all outputs 0 immediately, o_ready=1. Release, then send ctrl=0x00A5, data=0x1234 → o_valid=1, o_ctrl=0x00A5 one edge later.
- Stream 0x1..0x8 with i_ready=1 → outputs 0x1..0x8 on consecutive edges, o_count stays 1, no gaps.
- Send 0x10, 0x11, 0x12 with i_ready=0 → o_count=2 after the second, o_ready=0, 0x12 held upstream. Raise i_ready → outputs 0x10, 0x11, 0x12 in order.
- State FULL (0x20, 0x21), assert i_flush with i_valid=1 and data 0x22 → o_valid=0, o_ctrl=0, o_count=0. 0x20, 0x21 and 0x22 never appear.
- Simultaneous in & out in state ONE holding 0x30, input 0x31 → o_data=0x31, o_count=1.
- With PIPE_STAGE_PERF_EN, CNT_WIDTH=4: hold o_valid=1, i_ready=0 for 20 cycles → o_stall_cycles=0xF (saturated). Pulse i_perf_clear → 0. Without the macro → both counters read 0.
